// File: rtl/gtx_align_inserter.sv
// TX word stream to GTX 8b/10b: SYNC fill, periodic ALIGN pairs; 1-cycle registered latency.
// Backpressure: inready low for the 4 ALIGN words; optional force_align port under GTX_ALIGN_INS_FORCE_EN.
module gtx_align_inserter #(
  parameter int ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] indata,
  input  logic [1:0]  inisk,
  input  logic        invalid,
`ifdef GTX_ALIGN_INS_FORCE_EN
  input  logic        force_align,
`endif
  output logic        inready,
  output logic [15:0] outdata,
  output logic [1:0]  outisk,
  output logic        aligning,
  output logic        underrun
);

  typedef enum logic {S_ALIGN, S_DATA} state_t;

  localparam logic [7:0]  LAST_DW  = 8'(ALIGN_PERIOD - 3);
  localparam logic [15:0] ALIGN_W0 = 16'h4ABC;
  localparam logic [15:0] ALIGN_W1 = 16'h7B4A;
  localparam logic [15:0] SYNC_W0  = 16'h957C;
  localparam logic [15:0] SYNC_W1  = 16'hB5B5;

  state_t      state, state_n;
  logic        ph;
  logic [1:0]  wc, wc_n;
  logic [7:0]  cnt, cnt_n;
  logic        acc0, acc0_n;
  logic [15:0] outdata_n;
  logic [1:0]  outisk_n;
  logic        aligning_n, underrun_n;
  logic        force_req;

`ifdef GTX_ALIGN_INS_FORCE_EN
  logic force_pend, force_pend_n;

  assign force_req = force_align | force_pend;

  // Requests outside a DATA ph=1 slot wait for the next dword boundary.
  always_comb begin
    force_pend_n = force_pend | force_align;
    if (state == S_DATA && ph) force_pend_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) force_pend <= 1'b0;
    else     force_pend <= force_pend_n;
  end
`else
  assign force_req = 1'b0;
`endif

  assign inready = (state == S_DATA);

  always_comb begin
    state_n    = state;
    wc_n       = wc;
    cnt_n      = cnt;
    acc0_n     = 1'b0;
    outdata_n  = ph ? SYNC_W1 : SYNC_W0;
    outisk_n   = ph ? 2'b00 : 2'b01;
    aligning_n = 1'b0;
    underrun_n = 1'b0;
    case (state)
      S_ALIGN: begin
        aligning_n = 1'b1;
        outdata_n  = wc[0] ? ALIGN_W1 : ALIGN_W0;
        outisk_n   = wc[0] ? 2'b00 : 2'b01;
        wc_n       = 2'(wc + 2'd1);
        if (wc == 2'd3) state_n = S_DATA;
      end
      default: begin
        if (invalid) begin
          outdata_n = indata;
          outisk_n  = inisk;
        end else if (ph && acc0) begin
          underrun_n = 1'b1;
        end
        if (!ph) acc0_n = invalid;
        // ALIGN may only start on a dword boundary, so decide at ph=1.
        if (ph) begin
          if (cnt == LAST_DW || force_req) begin
            state_n = S_ALIGN;
            cnt_n   = 8'd0;
            wc_n    = 2'd0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_ALIGN;
      ph       <= 1'b0;
      wc       <= 2'd0;
      cnt      <= 8'd0;
      acc0     <= 1'b0;
      outdata  <= 16'h0000;
      outisk   <= 2'b00;
      aligning <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ~ph;
      wc       <= wc_n;
      cnt      <= cnt_n;
      acc0     <= acc0_n;
      outdata  <= outdata_n;
      outisk   <= outisk_n;
      aligning <= aligning_n;
      underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_gtx_align_inserter.sv
// Directed bench: reset, SYNC fill, periodic ALIGN at 256 and 4, underrun, mid-dword reset.
module tb_gtx_align_inserter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] indata = 16'h0000;
  logic [1:0]  inisk = 2'b00;
  logic        invalid = 1'b0;
  logic        inready, aligning, underrun;
  logic [15:0] outdata;
  logic [1:0]  outisk;

  logic [15:0] indata2 = 16'h1234;
  logic [1:0]  inisk2 = 2'b00;
  logic        invalid2 = 1'b1;
  logic        inready2, aligning2, underrun2;
  logic [15:0] outdata2;
  logic [1:0]  outisk2;

`ifdef GTX_ALIGN_INS_FORCE_EN
  logic force_align = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gtx_align_inserter #(.ALIGN_PERIOD(256)) dut (
    .clk(clk), .rst(rst), .indata(indata), .inisk(inisk), .invalid(invalid),
`ifdef GTX_ALIGN_INS_FORCE_EN
    .force_align(force_align),
`endif
    .inready(inready), .outdata(outdata), .outisk(outisk),
    .aligning(aligning), .underrun(underrun)
  );

  gtx_align_inserter #(.ALIGN_PERIOD(4)) dut4 (
    .clk(clk), .rst(rst), .indata(indata2), .inisk(inisk2), .invalid(invalid2),
`ifdef GTX_ALIGN_INS_FORCE_EN
    .force_align(force_align),
`endif
    .inready(inready2), .outdata(outdata2), .outisk(outisk2),
    .aligning(aligning2), .underrun(underrun2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected ALIGN word for a word index inside an ALIGN pair.
  function automatic logic [17:0] align_word(input int k);
    return (k % 2 == 0) ? {2'b01, 16'h4ABC} : {2'b00, 16'h7B4A};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [17:0] idle_tab [8];
  logic [15:0] nxt;
  logic [17:0] exp_w;
  int          m;

  initial begin
    idle_tab[0] = {2'b01, 16'h4ABC}; idle_tab[1] = {2'b00, 16'h7B4A};
    idle_tab[2] = {2'b01, 16'h4ABC}; idle_tab[3] = {2'b00, 16'h7B4A};
    idle_tab[4] = {2'b01, 16'h957C}; idle_tab[5] = {2'b00, 16'hB5B5};
    idle_tab[6] = {2'b01, 16'h957C}; idle_tab[7] = {2'b00, 16'hB5B5};

    // Reset state
    step();
    chk("rst_outdata", 32'(outdata), 32'h0000);
    chk("rst_outisk", 32'(outisk), 32'h0);
    chk("rst_inready", 32'(inready), 32'h0);
    chk("rst_aligning", 32'(aligning), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);

    // Idle after release: ALIGN pair then SYNC fill
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("idle_word%0d", k), {14'd0, outisk, outdata}, {14'd0, idle_tab[k]});
      chk($sformatf("idle_align%0d", k), 32'(aligning), 32'(k < 4));
      chk($sformatf("idle_underrun%0d", k), 32'(underrun), 32'h0);
      chk($sformatf("idle_inready%0d", k), 32'(inready), 32'(k >= 3));
    end

    // Reset mid-dword during DATA (9 words emitted -> next is ph=1)
    step();
    rst = 1'b1;
    #1;
    chk("midrst_outdata", 32'(outdata), 32'h0000);
    chk("midrst_outisk", 32'(outisk), 32'h0);
    chk("midrst_inready", 32'(inready), 32'h0);
    chk("midrst_aligning", 32'(aligning), 32'h0);
    step();
    rst = 1'b0;

    // Continuous data, ALIGN_PERIOD=256: 508 data words then 4 ALIGN words
    invalid = 1'b1;
    nxt = 16'h0000;
    for (int k = 0; k < 1100; k++) begin
      indata = nxt;
      inisk  = 2'b00;
      step();
      m = k % 512;
      exp_w = (m < 4) ? align_word(m) : {2'b00, nxt};
      if (m >= 4) nxt = nxt + 16'd1;
      chk($sformatf("cont_word%0d", k), {14'd0, outisk, outdata}, {14'd0, exp_w});
      chk($sformatf("cont_align%0d", k), 32'(aligning), 32'(m < 4));
      chk($sformatf("cont_inready%0d", k), 32'(inready), 32'(((k + 1) % 512) >= 4));
      if (k < 40) begin
        exp_w = ((k % 8) < 4) ? align_word(k % 8) : {2'b00, 16'h1234};
        chk($sformatf("p4_word%0d", k), {14'd0, outisk2, outdata2}, {14'd0, exp_w});
        chk($sformatf("p4_align%0d", k), 32'(aligning2), 32'((k % 8) < 4));
      end
    end

    // Underrun on a ph=1 word, then a full SYNC dword from invalid low at ph=0
    do_reset();
    for (int k = 0; k < 12; k++) begin
      invalid = (k != 7 && k != 8 && k != 9);
      indata  = 16'h1000 + 16'(k);
      inisk   = (k == 5) ? 2'b10 : 2'b00;
      step();
      if (k < 4)       exp_w = align_word(k);
      else if (k == 7) exp_w = {2'b00, 16'hB5B5};
      else if (k == 8) exp_w = {2'b01, 16'h957C};
      else if (k == 9) exp_w = {2'b00, 16'hB5B5};
      else             exp_w = {((k == 5) ? 2'b10 : 2'b00), 16'h1000 + 16'(k)};
      chk($sformatf("urun_word%0d", k), {14'd0, outisk, outdata}, {14'd0, exp_w});
      chk($sformatf("urun_pulse%0d", k), 32'(underrun), 32'(k == 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
